// File: rtl/lcd_sprite_compositor.sv
// LCD raster timing master and sprite mixer with per-frame sprite-0 collision flags.
// Optional scanline dimming of odd active lines is enabled by `COMPOSITOR_SCANLINE_DIM_EN.
module lcd_sprite_compositor #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FP       = 40,
    parameter int unsigned H_SYNC     = 128,
    parameter int unsigned H_BP       = 88,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BP       = 21,
    parameter int unsigned N_SPRITES  = 4,
    parameter int unsigned SPRITE_LAT = 2,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SPRITES*24-1:0]   sprite_pixel,
    input  logic [N_SPRITES-1:0]      sprite_valid,
    output logic [11:0]               lcd_xpos,
    output logic [11:0]               lcd_ypos,
    output logic                      frame_start,
    output logic                      lcd_hsync,
    output logic                      lcd_vsync,
    output logic                      lcd_de,
    output logic [23:0]               lcd_rgb,
    output logic [N_SPRITES-1:0]      collide
);

    localparam int unsigned CW      = 12;
    localparam int unsigned PW      = 24;
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;

    logic [CW-1:0]         h_cnt_q, h_cnt_d;
    logic [CW-1:0]         v_cnt_q, v_cnt_d;
    logic                  act_c;
    logic [CW-1:0]         xpos_q, xpos_d;
    logic [CW-1:0]         ypos_q, ypos_d;
    logic                  frame_start_q, frame_start_d;
    logic                  hs_q, hs_d;
    logic                  vs_q, vs_d;
    logic                  de_q, de_d;
    logic [SPRITE_LAT-1:0] hs_sr_q, hs_sr_d;
    logic [SPRITE_LAT-1:0] vs_sr_q, vs_sr_d;
    logic [SPRITE_LAT-1:0] de_sr_q, de_sr_d;
    logic                  lcd_hsync_q, lcd_hsync_d;
    logic                  lcd_vsync_q, lcd_vsync_d;
    logic                  lcd_de_q, lcd_de_d;
    logic [PW-1:0]         rgb_q, rgb_d;
    logic [PW-1:0]         pix_c;
    logic                  de_dly_c;
    logic [N_SPRITES-1:0]  hit_c;
    logic [N_SPRITES-1:0]  coll_acc_q, coll_acc_d;
    logic [N_SPRITES-1:0]  collide_q, collide_d;

    // Raster counters: sync, back porch, active, front porch
    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == CW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 12'd1;
        end
    end

    // Coordinate stage, with raw sync/de kept active-high alongside it
    always_comb begin
        act_c = (h_cnt_q >= CW'(H_START)) && (h_cnt_q < CW'(H_START + H_ACTIVE)) &&
                (v_cnt_q >= CW'(V_START)) && (v_cnt_q < CW'(V_START + V_ACTIVE));
        xpos_d        = act_c ? h_cnt_q - CW'(H_START) : '0;
        ypos_d        = act_c ? v_cnt_q - CW'(V_START) : '0;
        frame_start_d = act_c && (h_cnt_q == CW'(H_START)) && (v_cnt_q == CW'(V_START));
        hs_d          = h_cnt_q < CW'(H_SYNC);
        vs_d          = v_cnt_q < CW'(V_SYNC);
        de_d          = act_c;
        hs_sr_d       = SPRITE_LAT'({hs_sr_q, hs_q});
        vs_sr_d       = SPRITE_LAT'({vs_sr_q, vs_q});
        de_sr_d       = SPRITE_LAT'({de_sr_q, de_q});
    end

`ifdef COMPOSITOR_SCANLINE_DIM_EN
    logic [SPRITE_LAT-1:0] yodd_sr_q, yodd_sr_d;

    function automatic logic [PW-1:0] dim_px(input logic [PW-1:0] p);
        return {4'b0, p[20:17], 3'b0, p[13:9], 4'b0, p[4:1]};
    endfunction

    always_comb yodd_sr_d = SPRITE_LAT'({yodd_sr_q, ypos_q[0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) yodd_sr_q <= '0;
        else        yodd_sr_q <= yodd_sr_d;
    end
`endif

    // Priority mix: lowest valid index wins, else background
    always_comb begin
        de_dly_c = de_sr_q[SPRITE_LAT-1];
        pix_c    = BG_COLOR;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (sprite_valid[i]) pix_c = sprite_pixel[i*PW +: PW];
        end
`ifdef COMPOSITOR_SCANLINE_DIM_EN
        if (yodd_sr_q[SPRITE_LAT-1]) pix_c = dim_px(pix_c);
`endif
        rgb_d       = de_dly_c ? pix_c : '0;
        lcd_hsync_d = ~hs_sr_q[SPRITE_LAT-1];
        lcd_vsync_d = ~vs_sr_q[SPRITE_LAT-1];
        lcd_de_d    = de_dly_c;
    end

    // Collision accumulate; frame_start publishes and re-seeds with any same-clock hit
    always_comb begin
        hit_c = '0;
        for (int i = 1; i < N_SPRITES; i++) begin
            hit_c[i] = de_dly_c && sprite_valid[0] && sprite_valid[i];
        end
        coll_acc_d = coll_acc_q | hit_c;
        collide_d  = collide_q;
        if (frame_start_q) begin
            collide_d  = coll_acc_q | hit_c;
            coll_acc_d = hit_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            frame_start_q <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            hs_sr_q       <= '0;
            vs_sr_q       <= '0;
            de_sr_q       <= '0;
            lcd_hsync_q   <= 1'b1;
            lcd_vsync_q   <= 1'b1;
            lcd_de_q      <= 1'b0;
            rgb_q         <= '0;
            coll_acc_q    <= '0;
            collide_q     <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            hs_sr_q       <= hs_sr_d;
            vs_sr_q       <= vs_sr_d;
            de_sr_q       <= de_sr_d;
            lcd_hsync_q   <= lcd_hsync_d;
            lcd_vsync_q   <= lcd_vsync_d;
            lcd_de_q      <= lcd_de_d;
            rgb_q         <= rgb_d;
            coll_acc_q    <= coll_acc_d;
            collide_q     <= collide_d;
        end
    end

    assign lcd_xpos    = xpos_q;
    assign lcd_ypos    = ypos_q;
    assign frame_start = frame_start_q;
    assign lcd_hsync   = lcd_hsync_q;
    assign lcd_vsync   = lcd_vsync_q;
    assign lcd_de      = lcd_de_q;
    assign lcd_rgb     = rgb_q;
    assign collide     = collide_q;

endmodule

// File: tb/tb_lcd_sprite_compositor.sv
// Randomized bench for lcd_sprite_compositor on a small raster, checked against a raster-position model.
module tb_lcd_sprite_compositor;

    localparam int H_SYNC = 2, H_BP = 4, H_ACTIVE = 8, H_FP = 2;
    localparam int V_SYNC = 1, V_BP = 1, V_ACTIVE = 4, V_FP = 1;
    localparam int NS = 4, LAT = 2;
    localparam logic [23:0] BG = 24'h1F003F;
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [95:0]   sprite_pixel;
    logic [3:0]    sprite_valid;
    logic [11:0]   lcd_xpos, lcd_ypos;
    logic          frame_start, lcd_hsync, lcd_vsync, lcd_de;
    logic [23:0]   lcd_rgb;
    logic [3:0]    collide;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            n        = 0;
    logic [3:0]    cur_v;
    logic [95:0]   cur_p;
    logic [3:0]    acc_m, col_m;

    always #5 clk = ~clk;

    lcd_sprite_compositor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .N_SPRITES(NS), .SPRITE_LAT(LAT), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sprite_pixel(sprite_pixel), .sprite_valid(sprite_valid),
        .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .frame_start(frame_start),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_rgb(lcd_rgb), .collide(collide)
    );

    // Raster position p = number of counter steps since reset release
    function automatic int hp(input int p); return p % H_TOT; endfunction
    function automatic int vp(input int p); return (p / H_TOT) % V_TOT; endfunction
    function automatic bit act(input int p);
        return p >= 0 && hp(p) >= H_START && hp(p) < H_START + H_ACTIVE &&
               vp(p) >= V_START && vp(p) < V_START + V_ACTIVE;
    endfunction
    function automatic bit origin(input int p);
        return act(p) && hp(p) == H_START && vp(p) == V_START;
    endfunction

    function automatic logic [23:0] mix_m(input int p, input logic [3:0] v, input logic [95:0] px);
        logic [23:0] res;
        bit found;
        int r, g, b;
        if (!act(p)) return 24'h0;
        res = BG;
        found = 0;
        for (int i = 0; i < NS; i++) begin
            if (!found && v[i]) begin
                res = px[i*24 +: 24];
                found = 1;
            end
        end
`ifdef COMPOSITOR_SCANLINE_DIM_EN
        if ((vp(p) - V_START) % 2 == 1) begin
            r = (int'(res) / 65536) % 32;
            g = (int'(res) / 256) % 64;
            b = int'(res) % 32;
            res = 24'((r / 2) * 65536 + (g / 2) * 256 + (b / 2));
        end
`endif
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_xpos", 32'(lcd_xpos), 32'd0);
        chk("rst_ypos", 32'(lcd_ypos), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_hsync", 32'(lcd_hsync), 32'd1);
        chk("rst_vsync", 32'(lcd_vsync), 32'd1);
        chk("rst_de", 32'(lcd_de), 32'd0);
        chk("rst_rgb", 32'(lcd_rgb), 32'd0);
        chk("rst_collide", 32'(collide), 32'd0);
    endtask

    // Coordinates lag the counter by one step; panel outputs by LAT+2 steps
    task automatic check_all();
        int pc, po;
        pc = n - 1;
        po = n - LAT - 2;
        chk("xpos", 32'(lcd_xpos), act(pc) ? 32'(hp(pc) - H_START) : 32'd0);
        chk("ypos", 32'(lcd_ypos), act(pc) ? 32'(vp(pc) - V_START) : 32'd0);
        chk("frame_start", 32'(frame_start), 32'(origin(pc)));
        chk("hsync", 32'(lcd_hsync), (po >= 0 && hp(po) < H_SYNC) ? 32'd0 : 32'd1);
        chk("vsync", 32'(lcd_vsync), (po >= 0 && vp(po) < V_SYNC) ? 32'd0 : 32'd1);
        chk("de", 32'(lcd_de), 32'(act(po)));
        chk("rgb", 32'(lcd_rgb), 32'(mix_m(po, cur_v, cur_p)));
        chk("collide", 32'(collide), 32'(col_m));
    endtask

    // Inputs set now meet raster position q at the mixer
    task automatic gen(input int mode);
        int q;
        q = n + 1 - LAT - 2;
        cur_p = {$urandom, $urandom, $urandom};
        case (mode)
            1: for (int i = 0; i < NS; i++) cur_v[i] = ($urandom_range(0, 99) < 40);
            2: for (int i = 0; i < NS; i++) cur_v[i] = ($urandom_range(0, 99) < 4);
            3: cur_v = (act(q) && hp(q) - H_START == 5 && vp(q) - V_START == 1) ? 4'b1001 : 4'b0000;
            4: cur_v = act(q) ? 4'b0000 : 4'b1111;
            5: begin
                cur_v = {1'b0, 1'(($urandom % 2)), 1'b0, 1'(($urandom % 2))};
                cur_p[23:0]  = 24'h1C2E1B;
                cur_p[71:48] = 24'h080E07;
            end
            default: cur_v = 4'b0000;
        endcase
        sprite_valid = cur_v;
        sprite_pixel = cur_p;
    endtask

    task automatic run(input int cycles, input int mode);
        logic [3:0] hit;
        for (int k = 0; k < cycles; k++) begin
            gen(mode);
            @(posedge clk);
            n++;
            hit = (act(n - LAT - 2) && cur_v[0]) ? (cur_v & 4'b1110) : 4'b0000;
            if (origin(n - 2)) begin
                col_m = acc_m | hit;
                acc_m = hit;
            end else begin
                acc_m = acc_m | hit;
            end
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        n = 0;
        acc_m = '0;
        col_m = '0;
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        cur_v = '0;
        cur_p = '0;
        acc_m = '0;
        col_m = '0;
        sprite_valid = '0;
        sprite_pixel = '0;
        repeat (3) @(negedge clk);
        #1 check_reset();
        @(negedge clk);
        release_reset();

        run(240, 0);
        run(112, 5);
        run(224, 1);
        run(224, 2);
        run(112, 3);
        run(250, 0);
        run(224, 4);
        run(60, 1);

        #2 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        release_reset();
        run(300, 1);
        run(250, 0);
        run(112, 3);
        run(240, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
